// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared declarations for the binary neural-network layer engine:
//   - bnnState_t : FSM state encoding of the layer sequencer
//   - DEF_*      : default parameter values of the engine
//   - popcount() : number of set bits in a word of up to POP_MAX_W bits
// ---------------------------------------------------------------------------
package bnn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    FIRE  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } bnnState_t;

  localparam int DEF_DATA_W   = 28;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_WADDR_W  = 8;
  localparam int DEF_IN_WORDS = 4;
  localparam int DEF_N_OUT    = 8;
  localparam int DEF_ACC_W    = 8;
  localparam int DEF_THRESH   = 56;
  localparam int DEF_IN_BASE  = 0;
  localparam int DEF_OUT_BASE = 32;

  // Widest word popcount() accepts; narrower words are zero-extended.
  localparam int POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// ---------------------------------------------------------------------------
// bnn_xnor_popcount
// Combinational binary dot product of one activation word with one weight
// word: counts the bit positions where act and wgt agree.
// Ports:
//   act   [DATA_W-1:0] in  : activation word
//   wgt   [DATA_W-1:0] in  : weight word
//   count [CNT_W-1:0]  out : popcount(~(act ^ wgt))
// ---------------------------------------------------------------------------
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] wgt,
  output logic [CNT_W-1:0]  count
);

  logic [POP_MAX_W-1:0] matchBits;

  always_comb begin
    matchBits             = '0;
    matchBits[DATA_W-1:0] = ~(act ^ wgt);
    count                 = CNT_W'(popcount(matchBits));
  end

endmodule

// File: rtl/bnn_layer_engine.sv
// ---------------------------------------------------------------------------
// bnn_layer_engine
// Sequential evaluator of one binary fully-connected layer. For each of
// N_OUT neurons it streams IN_WORDS activation/weight word pairs from two
// 1-cycle-latency memories, accumulates the XNOR popcount, fires when the
// sum reaches THRESH, and finally writes the packed firing pattern to
// MEM0[OUT_BASE].
//
// Optional feature macro: BNN_RAW_SUM_EN
//   Adds iMODE (sampled together with iSTART). With iMODE=1 every neuron's
//   raw popcount sum is also written to MEM0[OUT_BASE+1+n] during FIRE.
//
// Ports:
//   iCLK, iRST        clock, synchronous active-high reset
//   iSTART            level start request, honoured only in IDLE
//   iCLR              synchronous abort/clear back to IDLE
//   iMODE             raw-sum write enable (BNN_RAW_SUM_EN builds only)
//   oMEM0RdADDR/_EN   activation read request, iMEM0RdDATA returns next cycle
//   oWRdADDR/_EN      weight read request, iWRdDATA returns next cycle
//   oMEM0WrADDR/DATA/_EN  result write port
//   oBUSY             high while a layer is being evaluated
//   oDONE             high once the result has been written, until iCLR
// ---------------------------------------------------------------------------
module bnn_layer_engine
  import bnn_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WADDR_W  = DEF_WADDR_W,
  parameter int IN_WORDS = DEF_IN_WORDS,
  parameter int N_OUT    = DEF_N_OUT,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int THRESH   = DEF_THRESH,
  parameter int IN_BASE  = DEF_IN_BASE,
  parameter int OUT_BASE = DEF_OUT_BASE
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iCLR,
`ifdef BNN_RAW_SUM_EN
  input  logic               iMODE,
`endif
  output logic [ADDR_W-1:0]  oMEM0RdADDR,
  output logic               oMEM0Rd_EN,
  input  logic [DATA_W-1:0]  iMEM0RdDATA,
  output logic [WADDR_W-1:0] oWRdADDR,
  output logic               oWRd_EN,
  input  logic [DATA_W-1:0]  iWRdDATA,
  output logic [ADDR_W-1:0]  oMEM0WrADDR,
  output logic [DATA_W-1:0]  oMEM0WrDATA,
  output logic               oMEM0Wr_EN,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam int NIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WIDX_W = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [NIDX_W-1:0] LAST_NEURON = NIDX_W'(N_OUT - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(IN_WORDS - 1);

  bnnState_t         state;
  logic [NIDX_W-1:0] neuronIdx;
  logic [WIDX_W-1:0] wordIdx;
  logic [ACC_W-1:0]  acc;
  logic [N_OUT-1:0]  result;

  logic              vld_p1;
  logic [CNT_W-1:0]  matchCnt_p1;
  logic [ACC_W-1:0]  accSum_p1;
  logic [N_OUT-1:0]  resultNext;
  logic              fireBit;

`ifdef BNN_RAW_SUM_EN
  logic rawMode;
`else
  localparam logic rawMode = 1'b0;
`endif

  function automatic logic [ACC_W-1:0] accAdd(input logic [ACC_W-1:0] a,
                                              input logic [CNT_W-1:0] c);
    return a + ACC_W'(c);
  endfunction

  function automatic logic [DATA_W-1:0] zeroExtAcc(input logic [ACC_W-1:0] a);
    return DATA_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] zeroExtResult(input logic [N_OUT-1:0] r);
    return DATA_W'(r);
  endfunction

  function automatic logic [ADDR_W-1:0] actAddr(input logic [WIDX_W-1:0] w);
    return ADDR_W'(IN_BASE + int'(w));
  endfunction

  function automatic logic [WADDR_W-1:0] wgtAddr(input logic [NIDX_W-1:0] n,
                                                input logic [WIDX_W-1:0] w);
    return WADDR_W'(int'(n) * IN_WORDS + int'(w));
  endfunction

  function automatic logic [ADDR_W-1:0] rawAddr(input logic [NIDX_W-1:0] n);
    return ADDR_W'(OUT_BASE + 1 + int'(n));
  endfunction

  // ---- p1: read data returning from both memories ----
  bnn_xnor_popcount #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) uPopcount (
    .act   (iMEM0RdDATA),
    .wgt   (iWRdDATA),
    .count (matchCnt_p1)
  );

  always_comb begin
    accSum_p1             = vld_p1 ? accAdd(acc, matchCnt_p1) : acc;
    fireBit               = (int'(acc) >= THRESH);
    resultNext            = result;
    resultNext[neuronIdx] = fireBit;
  end

  // ---- p0: sequencer, read issue and result writes ----
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      neuronIdx   <= '0;
      wordIdx     <= '0;
      acc         <= '0;
      result      <= '0;
      vld_p1      <= 1'b0;
`ifdef BNN_RAW_SUM_EN
      rawMode     <= 1'b0;
`endif
      oMEM0RdADDR <= '0;
      oMEM0Rd_EN  <= 1'b0;
      oWRdADDR    <= '0;
      oWRd_EN     <= 1'b0;
      oMEM0WrADDR <= '0;
      oMEM0WrDATA <= '0;
      oMEM0Wr_EN  <= 1'b0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
    end else if (iCLR) begin
      // Addresses and write data deliberately keep their last values.
      state      <= IDLE;
      neuronIdx  <= '0;
      wordIdx    <= '0;
      acc        <= '0;
      result     <= '0;
      vld_p1     <= 1'b0;
      oMEM0Rd_EN <= 1'b0;
      oWRd_EN    <= 1'b0;
      oMEM0Wr_EN <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
    end else begin
      // A read enable seen this cycle means its data is on the bus next cycle.
      vld_p1     <= oMEM0Rd_EN;
      acc        <= accSum_p1;
      oMEM0Rd_EN <= 1'b0;
      oWRd_EN    <= 1'b0;
      oMEM0Wr_EN <= 1'b0;

      case (state)
        IDLE: begin
          if (iSTART) begin
            state       <= FETCH;
            neuronIdx   <= '0;
            wordIdx     <= '0;
            acc         <= '0;
            result      <= '0;
`ifdef BNN_RAW_SUM_EN
            rawMode     <= iMODE;
`endif
            oMEM0RdADDR <= actAddr('0);
            oWRdADDR    <= wgtAddr('0, '0);
            oMEM0Rd_EN  <= 1'b1;
            oWRd_EN     <= 1'b1;
            oBUSY       <= 1'b1;
          end
        end

        FETCH: begin
          if (wordIdx == LAST_WORD) begin
            state <= DRAIN;
          end else begin
            wordIdx     <= wordIdx + 1'b1;
            oMEM0RdADDR <= actAddr(wordIdx + 1'b1);
            oWRdADDR    <= wgtAddr(neuronIdx, wordIdx + 1'b1);
            oMEM0Rd_EN  <= 1'b1;
            oWRd_EN     <= 1'b1;
          end
        end

        DRAIN: begin
          // accSum_p1 already includes the last word, so the raw sum can be
          // written during FIRE without adding a cycle.
          state <= FIRE;
          if (rawMode) begin
            oMEM0Wr_EN  <= 1'b1;
            oMEM0WrADDR <= rawAddr(neuronIdx);
            oMEM0WrDATA <= zeroExtAcc(accSum_p1);
          end
        end

        FIRE: begin
          result <= resultNext;
          acc    <= '0;
          if (neuronIdx == LAST_NEURON) begin
            state       <= WRITE;
            neuronIdx   <= '0;
            oMEM0Wr_EN  <= 1'b1;
            oMEM0WrADDR <= ADDR_W'(OUT_BASE);
            oMEM0WrDATA <= zeroExtResult(resultNext);
          end else begin
            state       <= FETCH;
            neuronIdx   <= neuronIdx + 1'b1;
            wordIdx     <= '0;
            oMEM0RdADDR <= actAddr('0);
            oWRdADDR    <= wgtAddr(neuronIdx + 1'b1, '0);
            oMEM0Rd_EN  <= 1'b1;
            oWRd_EN     <= 1'b1;
          end
        end

        WRITE: begin
          state <= DONE;
          oBUSY <= 1'b0;
        end

        DONE: begin
          // oDONE rises on the first DONE edge and holds; iSTART is ignored.
          oDONE <= 1'b1;
        end

        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// ---------------------------------------------------------------------------
// tb_bnn_layer_engine
// Directed bench for bnn_layer_engine at default parameters. Behavioural
// activation/weight memories with 1-cycle read latency feed the engine;
// expected result writes are queued when a run is started and popped by a
// write monitor. Build with BNN_RAW_SUM_EN to also exercise the raw-sum mode.
// ---------------------------------------------------------------------------
module tb_bnn_layer_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clr;
  logic        mode;
  logic [5:0]  rdAddr;
  logic        rdEn;
  logic [27:0] rdData;
  logic [7:0]  wAddr;
  logic        wEn;
  logic [27:0] wData;
  logic [5:0]  wrAddr;
  logic [27:0] wrData;
  logic        wrEn;
  logic        busy;
  logic        done;

  logic [27:0] actMem [64];
  logic [27:0] wMem   [256];

  typedef struct packed {
    logic [5:0]  addr;
    logic [27:0] data;
  } wrExp_t;

  wrExp_t expQ[$];
  wrExp_t popped;
  int     tests;
  int     fails;
  int     writeCount;

  bnn_layer_engine dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSTART      (start),
    .iCLR        (clr),
`ifdef BNN_RAW_SUM_EN
    .iMODE       (mode),
`endif
    .oMEM0RdADDR (rdAddr),
    .oMEM0Rd_EN  (rdEn),
    .iMEM0RdDATA (rdData),
    .oWRdADDR    (wAddr),
    .oWRd_EN     (wEn),
    .iWRdDATA    (wData),
    .oMEM0WrADDR (wrAddr),
    .oMEM0WrDATA (wrData),
    .oMEM0Wr_EN  (wrEn),
    .oBUSY       (busy),
    .oDONE       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle latency memories
  always @(posedge clk) begin
    if (rdEn) rdData <= actMem[rdAddr];
    if (wEn)  wData  <= wMem[wAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      writeCount++;
      tests++;
      assert (expQ.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected=no write",
               wrAddr, wrData);
      end
      if (expQ.size() != 0) begin
        popped = expQ.pop_front();
        check("wr_addr", {26'd0, wrAddr}, {26'd0, popped.addr});
        check("wr_data", {4'd0, wrData}, {4'd0, popped.data});
      end
    end
  end

  function automatic logic [27:0] modelResult();
    logic [27:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      int a;
      a = 0;
      for (int w = 0; w < 4; w++) begin
        logic [27:0] x;
        x = ~(actMem[w] ^ wMem[n * 4 + w]);
        a += $countones(x);
      end
      if (a >= 56) r[n] = 1'b1;
    end
    return r;
  endfunction

  task automatic pushExp(input logic [5:0] a, input logic [27:0] d);
    wrExp_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  // Starts a run and returns the number of edges after the sampling edge
  // until oDONE is seen high. holdStart keeps iSTART high (with a gap at 9).
  task automatic runLayer(input logic m, input bit holdStart, output int lat);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (holdStart && lat == 9)  start = 1'b0;
      if (holdStart && lat == 10) start = 1'b1;
      if (lat == 5) check("busy_mid_run", {31'd0, busy}, 32'd1);
      if (done === 1'b1) break;
    end
  endtask

  task automatic clearPulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic fillAll(input logic [27:0] a, input logic [27:0] w);
    for (int i = 0; i < 64; i++)  actMem[i] = a;
    for (int i = 0; i < 256; i++) wMem[i]   = w;
  endtask

  initial begin
    int lat;
    int wc;
    tests = 0; fails = 0; writeCount = 0;
    rst = 1'b1; start = 1'b0; clr = 1'b0; mode = 1'b0;
    fillAll(28'h0, 28'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_rden",   {31'd0, rdEn}, 32'd0);
    check("rst_wen",    {31'd0, wEn},  32'd0);
    check("rst_wren",   {31'd0, wrEn}, 32'd0);
    check("rst_rdaddr", {26'd0, rdAddr}, 32'd0);
    check("rst_waddr",  {24'd0, wAddr},  32'd0);
    check("rst_wraddr", {26'd0, wrAddr}, 32'd0);
    check("rst_wrdata", {4'd0, wrData},  32'd0);
    rst = 1'b0;

    // All ones: acc 112 everywhere -> 0xFF
    fillAll(28'hFFFFFFF, 28'hFFFFFFF);
    pushExp(6'd32, 28'h00000FF);
    runLayer(1'b0, 1'b0, lat);
    check("latency_ones", lat, 32'd50);
    check("queue_empty_ones", expQ.size(), 32'd0);
    // iSTART in DONE is ignored and oDONE holds
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    clearPulse();
    check("clr_done", {31'd0, done}, 32'd0);

    // Even neurons weight 0, odd all ones -> 0xAA
    for (int n = 0; n < 8; n++)
      for (int w = 0; w < 4; w++)
        wMem[n * 4 + w] = (n % 2 == 1) ? 28'hFFFFFFF : 28'h0;
    pushExp(6'd32, 28'h00000AA);
    runLayer(1'b0, 1'b0, lat);
    check("latency_alt", lat, 32'd50);
    clearPulse();

    // Threshold boundary: neuron0 sum 56, neuron1 sum 55 -> 0x01
    fillAll(28'hFFFFFFF, 28'h0);
    wMem[0] = 28'hFFFFFFF; wMem[1] = 28'hFFFFFFF;
    wMem[4] = 28'hFFFFFFF; wMem[5] = 28'h7FFFFFF;
    pushExp(6'd32, 28'h0000001);
    runLayer(1'b0, 1'b0, lat);
    clearPulse();

    // iSTART held through the run with a second pulse at cycle 10
    fillAll(28'hFFFFFFF, 28'hFFFFFFF);
    wc = writeCount;
    pushExp(6'd32, 28'h00000FF);
    runLayer(1'b0, 1'b1, lat);
    check("latency_held", lat, 32'd50);
    repeat (5) @(negedge clk);
    check("held_one_write", writeCount - wc, 32'd1);
    check("held_no_restart", {31'd0, busy}, 32'd0);
    check("held_done", {31'd0, done}, 32'd1);
    start = 1'b0;
    clearPulse();

    // iCLR at cycle 20 aborts; then a full run on random data
    for (int i = 0; i < 64; i++)  actMem[i] = 28'($urandom);
    for (int i = 0; i < 256; i++) wMem[i]   = 28'($urandom);
    wc = writeCount;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rden", {31'd0, rdEn}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (60) @(negedge clk);
    check("abort_no_write", writeCount - wc, 32'd0);
    pushExp(6'd32, modelResult());
    runLayer(1'b0, 1'b0, lat);
    check("latency_rand", lat, 32'd50);
    clearPulse();

    // iCLR and iSTART together in IDLE: iCLR wins
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clr_beats_start", {31'd0, busy}, 32'd0);

    // Reset mid-run with iCLR and iSTART also high: abort, no access
    wc = writeCount;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 begin rst = 1'b1; clr = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 begin rst = 1'b0; clr = 1'b0; start = 1'b0; end
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_rden", {31'd0, rdEn}, 32'd0);
    check("rstmid_wen",  {31'd0, wEn},  32'd0);
    check("rstmid_rdaddr", {26'd0, rdAddr}, 32'd0);
    repeat (60) @(negedge clk);
    check("rstmid_no_write", writeCount - wc, 32'd0);

`ifdef BNN_RAW_SUM_EN
    // Raw sums at 33..40, then the packed result at 32
    fillAll(28'hFFFFFFF, 28'hFFFFFFF);
    for (int n = 0; n < 8; n++) pushExp(6'(33 + n), 28'h0000070);
    pushExp(6'd32, 28'h00000FF);
    runLayer(1'b1, 1'b0, lat);
    check("latency_raw", lat, 32'd50);
    clearPulse();
`endif

    repeat (3) @(negedge clk);
    check("queue_empty_end", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bnn_layer_engine.md
BNN_LAYER_ENGINE -- requirements
Module: bnn_layer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 28: activation, weight and memory word width.
REQ-002 SHALL have parameter ADDR_W, default 6: MEM0 address width.
REQ-003 SHALL have parameter WADDR_W, default 8: weight memory address width.
REQ-004 SHALL have parameter IN_WORDS, default 4: input words per neuron.
REQ-005 SHALL have parameter N_OUT, default 8: neuron count, 1..DATA_W.
REQ-006 SHALL have parameter ACC_W, default 8: popcount width, at least clog2(IN_WORDS*DATA_W+1).
REQ-007 SHALL have parameter THRESH, default 56: firing threshold.
REQ-008 SHALL have parameters IN_BASE, default 0, and OUT_BASE, default 32: MEM0 base addresses.
REQ-009 SHALL have port iCLK, input, 1: the single clock; all logic on its rising edge.
REQ-010 SHALL have port iRST, input, 1: reset, synchronous, active-high.
REQ-011 SHALL have port iSTART, input, 1: level start request, sampled in IDLE.
REQ-012 SHALL have port iCLR, input, 1: synchronous abort and clear.
REQ-013 SHALL have ports oMEM0RdADDR (output, ADDR_W), oMEM0Rd_EN (output, 1) and iMEM0RdDATA (input, DATA_W): activation read port.
REQ-014 SHALL have ports oWRdADDR (output, WADDR_W), oWRd_EN (output, 1) and iWRdDATA (input, DATA_W): weight read port.
REQ-015 SHALL have ports oMEM0WrADDR (output, ADDR_W), oMEM0WrDATA (output, DATA_W) and oMEM0Wr_EN (output, 1): result write port.
REQ-016 SHALL have ports oBUSY (output, 1), high outside IDLE/DONE, and oDONE (output, 1), high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, FIRE, WRITE and DONE.
REQ-018 IDLE SHALL go to FETCH when iSTART=1.
REQ-019 FETCH SHALL issue IN_WORDS consecutive reads, one per cycle, with activation address IN_BASE+w and weight address n*IN_WORDS+w; both enables SHALL be high together.
REQ-020 Both memories SHALL have 1-cycle read latency; the engine SHALL add popcount(~(act ^ wgt)) to the accumulator on the cycle after each read.
REQ-021 DRAIN SHALL last 1 cycle and absorb the last read.
REQ-022 FIRE SHALL shift bit (acc >= THRESH) into bit n of the result register, clear the accumulator, then go to FETCH for n+1, or to WRITE after neuron N_OUT-1.
REQ-023 WRITE SHALL assert oMEM0Wr_EN for exactly 1 cycle, with oMEM0WrADDR=OUT_BASE and data equal to the result zero-extended to DATA_W.
REQ-024 DONE SHALL hold oDONE=1 until iCLR, then go to IDLE; iSTART in DONE SHALL be ignored.
REQ-025 Latency from the iSTART-sampling edge to oDONE=1 SHALL be N_OUT*(IN_WORDS+2)+2 cycles (50 at defaults).
REQ-026 iSTART while oBUSY=1 SHALL be ignored.
REQ-027 iCLR in any state SHALL go to IDLE next cycle, deassert all enables and clear the accumulator, neuron counter and result; iCLR and iSTART in the same cycle: iCLR wins.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W or 2^WADDR_W.
REQ-029 Enables SHALL be 0 outside FETCH/WRITE, and address outputs SHALL hold their last value.

Reset
REQ-030 iRST=1 SHALL force IDLE; all outputs, the accumulator, the neuron counter and the result SHALL go to 0 on that edge.
REQ-031 iRST mid-operation SHALL abort with no further memory access; iRST SHALL take priority over iCLR and iSTART.

Configuration
REQ-032 Macro BNN_RAW_SUM_EN defined SHALL add input port iMODE (1 bit, sampled with iSTART).
REQ-033 With the macro and iMODE=1, each FIRE SHALL also write the zero-extended acc to OUT_BASE+1+n.
REQ-034 Each such write SHALL be a single cycle, and latency SHALL be unchanged.
REQ-035 Without the macro, iMODE and the raw-sum writes SHALL be absent, and behaviour SHALL equal iMODE=0.

Structure
REQ-036 Shared package bnn_pkg SHALL hold the FSM state enum, the default parameter constants and a popcount function.
REQ-037 The single sub-module bnn_xnor_popcount SHALL be combinational, DATA_W-parameterised, and take act and wgt in and give a count out.

Verification
REQ-038 All activations and weights 0x FFFFFFF: acc=112 per neuron -> one write of 0x00000FF at address 32, oDONE at cycle 50.
REQ-039 Activations all ones, weights of even neurons 0, odd neurons all ones -> write data 0x00000AA.
REQ-040 Threshold boundary, neuron 0 acc=56 and neuron 1 acc=55 -> bit0=1, bit1=0.
REQ-041 iSTART held through the run plus a second pulse at cycle 10 -> exactly one write, and no restart until iCLR.
REQ-042 iCLR at cycle 20 -> IDLE next cycle, no write, and oBUSY=0; then iSTART -> a full correct run.
REQ-043 BNN_RAW_SUM_EN with iMODE=1 and the REQ-038 data -> 8 writes of 0x0000070 at addresses 33..40, then the packed 0x00000FF write at 32.
